// File: rtl/mf_peak_trigger_if.sv
// Trigger-record stream from mf_peak_trigger to the record FIFO / readout logic.
interface mf_peak_trigger_if #(
   parameter int TDATA_W = 22
);
   logic [TDATA_W-1:0] tdata;
   logic               tvalid;
   logic               tready;

   modport master (output tdata, output tvalid, input tready);
   modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/mf_peak_trigger.sv
// Matched-filter peak trigger: per-lane magnitude, threshold hit detection, windowed
// peak search and one {peak, lane, offset} record per trigger over valid/ready.
module mf_peak_trigger #(
   parameter int NBITS        = 18,
   parameter int NSAMPS       = 8,
   parameter int WINDOW       = 4,
   parameter int HOLDOFF_BITS = 8
) (
   input  logic                      aclk,
   input  logic                      aresetn,
   input  logic [NBITS*NSAMPS-1:0]   data_i,
   input  logic [NBITS-2:0]          threshold_i,
   input  logic [HOLDOFF_BITS-1:0]   holdoff_i,
   input  logic                      enable_i,
   input  logic                      clear_i,
   output logic                      trig_o,
   output logic [15:0]               dropped_o,
   mf_peak_trigger_if.master         rec
);
   localparam int MAG_W  = NBITS - 1;
   localparam int LANE_W = $clog2(NSAMPS);
   localparam int OFF_W  = $clog2(WINDOW);

   typedef enum logic [1:0] {IDLE, SEARCH, EMIT, HOLDOFF} state_t;

   function automatic logic [MAG_W-1:0] sat_abs(input logic signed [NBITS-1:0] x);
      logic signed [NBITS-1:0] neg;
      neg = -x;
      if (x[NBITS-1] && (x[NBITS-2:0] == '0)) return '1;
      else if (x[NBITS-1])                     return neg[MAG_W-1:0];
      else                                     return x[MAG_W-1:0];
   endfunction

   logic [MAG_W-1:0]        mag_p1 [NSAMPS];
   logic                    hit_p2;
   logic [MAG_W-1:0]        max_p2;
   logic [LANE_W-1:0]       lane_p2;
   logic                    hit_c;
   logic [MAG_W-1:0]        max_c;
   logic [LANE_W-1:0]       lane_c;

   state_t                  state, state_nxt;
   logic [MAG_W-1:0]        peak, peak_nxt;
   logic [LANE_W-1:0]       lane, lane_nxt;
   logic [OFF_W-1:0]        offset, offset_nxt;
   logic [OFF_W-1:0]        cnt, cnt_nxt;
   logic [HOLDOFF_BITS-1:0] hold_cnt, hold_nxt;
   logic                    trig_nxt;

   // ---- stage 1: saturated per-lane magnitude
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int i = 0; i < NSAMPS; i++) mag_p1[i] <= '0;
      end else begin
         for (int i = 0; i < NSAMPS; i++) mag_p1[i] <= sat_abs($signed(data_i[NBITS*i +: NBITS]));
      end
   end

   // ---- stage 2: threshold hit and per-clock maximum (strict compare keeps lowest lane)
   always_comb begin
      hit_c  = 1'b0;
      max_c  = mag_p1[0];
      lane_c = '0;
      for (int i = 0; i < NSAMPS; i++) begin
         if (mag_p1[i] > threshold_i) hit_c = 1'b1;
         if (mag_p1[i] > max_c) begin
            max_c  = mag_p1[i];
            lane_c = LANE_W'(i);
         end
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         hit_p2  <= 1'b0;
         max_p2  <= '0;
         lane_p2 <= '0;
      end else begin
         hit_p2  <= hit_c;
         max_p2  <= max_c;
         lane_p2 <= lane_c;
      end
   end

   // ---- trigger FSM: search window, hold the record until accepted, optional holdoff
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state    <= IDLE;
         peak     <= '0;
         lane     <= '0;
         offset   <= '0;
         cnt      <= '0;
         hold_cnt <= '0;
         trig_o   <= 1'b0;
      end else begin
         state    <= state_nxt;
         peak     <= peak_nxt;
         lane     <= lane_nxt;
         offset   <= offset_nxt;
         cnt      <= cnt_nxt;
         hold_cnt <= hold_nxt;
         trig_o   <= trig_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      peak_nxt   = peak;
      lane_nxt   = lane;
      offset_nxt = offset;
      cnt_nxt    = cnt;
      hold_nxt   = hold_cnt;
      trig_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (hit_p2 && enable_i) begin
               trig_nxt   = 1'b1;
               peak_nxt   = max_p2;
               lane_nxt   = lane_p2;
               offset_nxt = '0;
               cnt_nxt    = OFF_W'(1);
               state_nxt  = SEARCH;
            end
         end
         SEARCH: begin
            if (max_p2 > peak) begin
               peak_nxt   = max_p2;
               lane_nxt   = lane_p2;
               offset_nxt = cnt;
            end
            cnt_nxt = cnt + 1'b1;
            if (cnt == OFF_W'(WINDOW - 1)) state_nxt = EMIT;
         end
         EMIT: begin
            if (rec.tready) begin
               if (holdoff_i == '0) begin
                  state_nxt = IDLE;
               end else begin
                  hold_nxt  = holdoff_i;
                  state_nxt = HOLDOFF;
               end
            end
         end
         HOLDOFF: begin
            hold_nxt = hold_cnt - 1'b1;
            if (hold_cnt == HOLDOFF_BITS'(1)) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign rec.tvalid = (state == EMIT);
   assign rec.tdata  = {peak, lane, offset};

   // Hits that arrive while a record is stalled are lost; clear takes priority.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         dropped_o <= '0;
      end else if (clear_i) begin
         dropped_o <= '0;
      end else if ((state == EMIT) && hit_p2 && !rec.tready && (dropped_o != 16'hFFFF)) begin
         dropped_o <= dropped_o + 16'd1;
      end
   end
endmodule

// File: tb/tb_mf_peak_trigger.sv
// Bench for mf_peak_trigger: stimulus tables (directed and random) are turned into
// expected per-cycle outputs by an event-level record model, then replayed on the DUT.
module tb_mf_peak_trigger;
   localparam int NBITS        = 18;
   localparam int NSAMPS       = 8;
   localparam int WINDOW       = 4;
   localparam int HOLDOFF_BITS = 8;
   localparam int TDATA_W      = NBITS - 1 + 3 + 2;
   localparam int L            = 300;
   localparam int THR          = 1000;

   logic                    aclk = 1'b0;
   logic                    aresetn;
   logic [NBITS*NSAMPS-1:0] data;
   logic [NBITS-2:0]        threshold;
   logic [HOLDOFF_BITS-1:0] holdoff;
   logic                    enable;
   logic                    clear;
   logic                    trig;
   logic [15:0]             dropped;

   mf_peak_trigger_if #(.TDATA_W(TDATA_W)) rec ();

   mf_peak_trigger #(
      .NBITS(NBITS), .NSAMPS(NSAMPS), .WINDOW(WINDOW), .HOLDOFF_BITS(HOLDOFF_BITS)
   ) dut (
      .aclk(aclk), .aresetn(aresetn), .data_i(data), .threshold_i(threshold),
      .holdoff_i(holdoff), .enable_i(enable), .clear_i(clear), .trig_o(trig),
      .dropped_o(dropped), .rec(rec)
   );

   always #5 aclk = ~aclk;

   int                 st_d    [L][NSAMPS];
   bit                 st_rdy  [L];
   bit                 st_en   [L];
   bit                 st_clr  [L];
   int                 st_hold [L];
   bit                 ex_trig [L];
   bit                 ex_vld  [L];
   bit                 ex_ev   [L];
   logic [TDATA_W-1:0] ex_tdata[L];
   int                 ex_drop [L];
   int                 cur;
   bit                 checking = 1'b0;
   int                 n_cmp = 0;
   int                 n_bad = 0;

   task automatic check(input string name, input longint act, input longint req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d, required %0d", name, $time, act, req);
      end
   endtask

   function automatic int mag(input int v);
      int m;
      m = (v < 0) ? -v : v;
      return (m > 131071) ? 131071 : m;
   endfunction

   // Hit visible in clock c comes from the samples driven in clock c-2.
   function automatic bit mhit(input int c);
      if (c < 2) return 1'b0;
      for (int l = 0; l < NSAMPS; l++) if (mag(st_d[c-2][l]) > THR) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [TDATA_W-1:0] pack(input int pk, input int ln, input int of);
      logic [NBITS-2:0] p;
      logic [2:0]       l3;
      logic [1:0]       o2;
      p = pk[NBITS-2:0]; l3 = ln[2:0]; o2 = of[1:0];
      return {p, l3, o2};
   endfunction

   task automatic build_model();
      int c, e, best, bl, bo;
      for (int i = 0; i < L; i++) begin
         ex_trig[i] = 1'b0; ex_vld[i] = 1'b0; ex_ev[i] = 1'b0; ex_tdata[i] = '0; ex_drop[i] = 0;
      end
      c = 0;
      while (c < L - 8) begin
         if (mhit(c) && st_en[c]) begin
            ex_trig[c+1] = 1'b1;
            best = -1; bl = 0; bo = 0;
            for (int k = 0; k < WINDOW; k++)
               for (int l = 0; l < NSAMPS; l++)
                  if (mag(st_d[c-2+k][l]) > best) begin
                     best = mag(st_d[c-2+k][l]); bl = l; bo = k;
                  end
            e = c + WINDOW;
            while (e < L && !st_rdy[e]) begin
               ex_vld[e] = 1'b1; ex_tdata[e] = pack(best, bl, bo); ex_ev[e] = mhit(e);
               e++;
            end
            if (e >= L) break;
            ex_vld[e] = 1'b1; ex_tdata[e] = pack(best, bl, bo);
            c = e + 1 + st_hold[e];
         end else begin
            c++;
         end
      end
      for (int i = 0; i < L - 1; i++)
         ex_drop[i+1] = st_clr[i] ? 0 : ((ex_drop[i] + int'(ex_ev[i]) > 65535) ? 65535
                                                                              : ex_drop[i] + int'(ex_ev[i]));
   endtask

   task automatic clear_stim();
      for (int i = 0; i < L; i++) begin
         for (int l = 0; l < NSAMPS; l++) st_d[i][l] = 0;
         st_rdy[i] = 1'b1; st_en[i] = 1'b1; st_clr[i] = 1'b0; st_hold[i] = 0;
      end
   endtask

   task automatic gen_random(input int dens, input int rdy_pct, input int max_hold);
      int r;
      clear_stim();
      for (int i = 0; i < L - 12; i++) begin
         for (int l = 0; l < NSAMPS; l++) begin
            r = int'($urandom_range(0, 99));
            if (r < dens)       st_d[i][l] = int'($urandom_range(0, 262143)) - 131072;
            else if (r == dens) st_d[i][l] = -131072;
            else if (r > 96)    st_d[i][l] = (r == 97) ? 1000 : ((r == 98) ? -1000 : 1001);
            else                st_d[i][l] = int'($urandom_range(0, 2000)) - 1000;
         end
         st_rdy[i]  = (int'($urandom_range(0, 99)) < rdy_pct);
         st_en[i]   = (int'($urandom_range(0, 99)) < 90);
         st_clr[i]  = (int'($urandom_range(0, 99)) < 3);
         st_hold[i] = int'($urandom_range(0, max_hold));
      end
   endtask

   task automatic drive(input int c);
      int v;
      for (int l = 0; l < NSAMPS; l++) begin
         v = st_d[c][l];
         data[NBITS*l +: NBITS] = v[NBITS-1:0];
      end
      v          = st_hold[c];
      holdoff    = v[HOLDOFF_BITS-1:0];
      rec.tready = st_rdy[c];
      enable     = st_en[c];
      clear      = st_clr[c];
   endtask

   task automatic zero_inputs();
      data = '0; holdoff = '0; rec.tready = 1'b1; enable = 1'b1; clear = 1'b0;
   endtask

   task automatic run_phase();
      build_model();
      checking = 1'b0;
      aresetn  = 1'b0;
      zero_inputs();
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      check("reset trig", trig, 0);
      check("reset tvalid", rec.tvalid, 0);
      check("reset tdata", rec.tdata, 0);
      check("reset dropped", dropped, 0);
      @(posedge aclk); #1;
      aresetn = 1'b1;
      for (int c = 0; c < L; c++) begin
         if (c > 0) begin @(posedge aclk); #1; end
         drive(c);
         cur      = c;
         checking = 1'b1;
      end
      @(posedge aclk); #1;
      checking = 1'b0;
   endtask

   always @(negedge aclk) begin
      if (checking) begin
         check($sformatf("trig c%0d", cur), trig, ex_trig[cur]);
         check($sformatf("tvalid c%0d", cur), rec.tvalid, ex_vld[cur]);
         if (ex_vld[cur]) check($sformatf("tdata c%0d", cur), rec.tdata, ex_tdata[cur]);
         check($sformatf("dropped c%0d", cur), dropped, ex_drop[cur]);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: bench did not finish, required completion");
      $fatal(1);
   end

   initial begin
      int sum, found, v;
      threshold = NBITS'(THR) ;
      aresetn   = 1'b0;
      zero_inputs();

      // All lanes exactly at the threshold: never a hit.
      clear_stim();
      for (int i = 5; i < 25; i++) for (int l = 0; l < NSAMPS; l++) st_d[i][l] = 1000;
      for (int i = 25; i < 35; i++) for (int l = 0; l < NSAMPS; l++) st_d[i][l] = -1000;
      run_phase();
      sum = 0;
      for (int i = 0; i < L; i++) sum += int'(ex_trig[i]) + int'(ex_vld[i]);
      check("pin equal-threshold no trigger", sum, 0);

      // Single negative sample on lane 5.
      clear_stim();
      st_d[10][5] = -1500;
      run_phase();
      check("pin single trig@13", ex_trig[13], 1);
      check("pin single tvalid@16", ex_vld[16], 1);
      check("pin single tvalid@17", ex_vld[17], 0);
      check("pin single tdata", ex_tdata[16], (1500 << 5) | (5 << 2) | 0);

      // Earliest of two equal peaks wins.
      clear_stim();
      st_d[10][2] = 1200; st_d[12][7] = 3000; st_d[13][1] = 3000;
      run_phase();
      check("pin earliest-peak tdata", ex_tdata[16], (3000 << 5) | (7 << 2) | 2);
      sum = 0;
      for (int i = 0; i < L; i++) sum += int'(ex_trig[i]);
      check("pin earliest-peak trig count", sum, 1);

      // Most-negative sample saturates.
      clear_stim();
      st_d[10][0] = -131072;
      run_phase();
      check("pin saturate tdata", ex_tdata[16], (131071 << 5) | (0 << 2) | 0);

      // Backpressure with continuous hits, holdoff 5, then clear.
      clear_stim();
      for (int i = 10; i < 46; i++) st_d[i][3] = 2000;
      for (int i = 16; i < 26; i++) st_rdy[i] = 1'b0;
      for (int i = 0; i < L; i++) st_hold[i] = 5;
      st_clr[40] = 1'b1;
      run_phase();
      check("pin stall dropped@26", ex_drop[26], 10);
      sum = 0;
      for (int i = 27; i < 33; i++) sum += int'(ex_trig[i]);
      check("pin holdoff quiet", sum, 0);
      check("pin retrigger@33", ex_trig[33], 1);
      check("pin dropped before clear", ex_drop[40], 10);
      check("pin dropped after clear", ex_drop[41], 0);

      // Randomised traffic at several densities / backpressure levels.
      gen_random(2, 70, 6);  run_phase();
      gen_random(5, 40, 3);  run_phase();
      gen_random(1, 90, 0);  run_phase();
      gen_random(10, 20, 2); run_phase();
      gen_random(3, 100, 0); run_phase();

      // Asynchronous reset while a record is stalled.
      checking = 1'b0;
      aresetn  = 1'b0;
      zero_inputs();
      repeat (2) @(posedge aclk);
      #1;
      aresetn = 1'b1;
      v = -1500;
      data[NBITS*5 +: NBITS] = v[NBITS-1:0];
      rec.tready = 1'b0;
      found = 0;
      for (int k = 0; k < 20 && found == 0; k++) begin
         @(negedge aclk);
         if (rec.tvalid) found = 1;
      end
      check("stalled record appears", found, 1);
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      check("dropped counting before reset", (dropped != 0), 1);
      #2;
      aresetn = 1'b0;
      #1;
      check("async reset tvalid", rec.tvalid, 0);
      check("async reset dropped", dropped, 0);
      check("async reset trig", trig, 0);
      @(posedge aclk); #1;
      data       = '0;
      rec.tready = 1'b1;
      aresetn    = 1'b1;
      for (int k = 0; k < 15; k++) begin
         @(negedge aclk);
         check("post-reset tvalid", rec.tvalid, 0);
         check("post-reset trig", trig, 0);
         check("post-reset dropped", dropped, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
